wur: RTL and testbench

//  UR write-back path for one SMC: scatters bytes of dr_wur_d into a 128-bit UR line using per-lane 4-bit byte indices.

---
 rtl/smc_ur_pkg.sv | 70 +++++++
 rtl/wur_if.sv | 33 +++
 rtl/wur_byte_scatter.sv | 34 +++
 rtl/wur.sv | 195 +++++++++++++++++++
 tb/tb_wur.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smc_ur_pkg.sv
// -----------------------------------------------------------------------------
// smc_ur_pkg
// Shared definitions for the SMC UR blocks (write-back wur and the UR read
// block): command field offsets, UR-RAM geometry, line/command types, the wur
// FSM state encoding and a command decode helper.
// -----------------------------------------------------------------------------
package smc_ur_pkg;

  // Command word layout
  localparam int unsigned CMD_W       = 97;
  localparam int unsigned VLD_BIT     = 96;
  localparam int unsigned SMC_ID_MSB  = 95;
  localparam int unsigned SMC_ID_LSB  = 91;
  localparam int unsigned UR_ID_MSB   = 90;
  localparam int unsigned UR_ID_LSB   = 88;
  localparam int unsigned UR_ADDR_MSB = 87;
  localparam int unsigned UR_ADDR_LSB = 80;
  localparam int unsigned LANE0_MSB   = 79;
  localparam int unsigned LANE_W      = 5;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned N_LANES     = 16;

  // Field widths
  localparam int unsigned SMC_ID_W  = SMC_ID_MSB - SMC_ID_LSB + 1;
  localparam int unsigned UR_ID_W   = UR_ID_MSB - UR_ID_LSB + 1;
  localparam int unsigned UR_ADDR_W = UR_ADDR_MSB - UR_ADDR_LSB + 1;

  // UR-RAM geometry
  localparam int unsigned UR_IDS   = 8;
  localparam int unsigned UR_DEPTH = 256;
  localparam int unsigned N_LINES  = UR_IDS * UR_DEPTH;
  localparam int unsigned KEY_W    = UR_ID_W + UR_ADDR_W;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned LINE_W   = N_LANES * BYTE_W;

  typedef logic [LINE_W-1:0] ur_line_t;
  typedef logic [CMD_W-1:0]  ur_cmd_raw_t;
  typedef logic [KEY_W-1:0]  ur_key_t;

  typedef struct packed {
    logic                               vld;
    logic [SMC_ID_W-1:0]                smc_id;
    logic [UR_ID_W-1:0]                 ur_id;
    logic [UR_ADDR_W-1:0]               ur_addr;
    logic [N_LANES-1:0][IDX_W-1:0]      idx;
    logic [N_LANES-1:0]                 lane_vld;
  } ur_cmd_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } wur_state_e;

  // Unpack a raw command word; lane g occupies a 5-bit slot {idx[3:0], vld}
  // counting down from LANE0_MSB.
  function automatic ur_cmd_t decode_cmd(input ur_cmd_raw_t raw);
    ur_cmd_t c;
    c.vld     = raw[VLD_BIT];
    c.smc_id  = raw[SMC_ID_MSB:SMC_ID_LSB];
    c.ur_id   = raw[UR_ID_MSB:UR_ID_LSB];
    c.ur_addr = raw[UR_ADDR_MSB:UR_ADDR_LSB];
    for (int g = 0; g < int'(N_LANES); g++) begin
      c.idx[g]      = raw[int'(LANE0_MSB) - int'(LANE_W) * g -: IDX_W];
      c.lane_vld[g] = raw[int'(LANE0_MSB) - int'(LANE_W) * g - int'(IDX_W)];
    end
    return c;
  endfunction

endpackage : smc_ur_pkg

// File: rtl/wur_if.sv
// -----------------------------------------------------------------------------
// wur_if
// Bus bundle for the UR write-back block.
//   cru_wur   command word (see smc_ur_pkg for layout)
//   dr_wur_d  write data, sampled with the command
//   wur_rdy   block accepts commands
//   wur_done  one-cycle pulse per committed command
//   rd_en/rd_id/rd_addr  line read request
//   rd_data   line read data, one cycle after rd_en
// master = command/read requester, slave = wur.
// -----------------------------------------------------------------------------
interface wur_if;
  import smc_ur_pkg::*;

  ur_cmd_raw_t          cru_wur;
  ur_line_t             dr_wur_d;
  logic                 wur_rdy;
  logic                 wur_done;
  logic                 rd_en;
  logic [UR_ID_W-1:0]   rd_id;
  logic [UR_ADDR_W-1:0] rd_addr;
  ur_line_t             rd_data;

  modport master (
    output cru_wur, dr_wur_d, rd_en, rd_id, rd_addr,
    input  wur_rdy, wur_done, rd_data
  );

  modport slave (
    input  cru_wur, dr_wur_d, rd_en, rd_id, rd_addr,
    output wur_rdy, wur_done, rd_data
  );
endinterface : wur_if

// File: rtl/wur_byte_scatter.sv
// -----------------------------------------------------------------------------
// wur_byte_scatter
// Combinational byte scatter: starting from base_i, lane g's data byte
// data_i[8g+:8] is placed at byte position idx_i[g] when lane_vld_i[g] is set.
// Lanes are applied in ascending order, so on a duplicate idx the highest
// lane wins.
// Ports:
//   base_i      line being modified
//   data_i      16 lane data bytes
//   idx_i       per-lane destination byte index
//   lane_vld_i  per-lane enable
//   merged_c_o  resulting line (combinational)
// -----------------------------------------------------------------------------
module wur_byte_scatter
  import smc_ur_pkg::*;
(
  input  ur_line_t                      base_i,
  input  ur_line_t                      data_i,
  input  logic [N_LANES-1:0][IDX_W-1:0] idx_i,
  input  logic [N_LANES-1:0]            lane_vld_i,
  output ur_line_t                      merged_c_o
);

  // Later lanes overwrite earlier ones on conflict
  always_comb begin
    merged_c_o = base_i;
    for (int g = 0; g < int'(N_LANES); g++) begin
      if (lane_vld_i[g]) begin
        merged_c_o[{idx_i[g], 3'b000} +: BYTE_W] = data_i[BYTE_W * g +: BYTE_W];
      end
    end
  end

endmodule : wur_byte_scatter

// File: rtl/wur.sv
// -----------------------------------------------------------------------------
// wur
// UR write-back path for one SMC. Scatters the bytes of dr_wur_d into a
// 128-bit UR line using per-lane byte indices and owns the 8x256x128 UR-RAM.
// A two-stage read-modify-write pipeline (S1 capture + RAM read, S2 merge +
// RAM write) forwards the line written on the previous edge, so back-to-back
// commands to one line merge correctly. An independent read-first port serves
// the UR read block.
// Optional feature macro: WUR_INIT_EN -- after reset, clear all 2048 lines
// (one per cycle) before accepting commands.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    wur_if.slave (command, data, rdy, done, read port)
// Parameter:
//   LOCAL_SMC_ID  commands with any other smc_id are ignored
// -----------------------------------------------------------------------------
module wur
  import smc_ur_pkg::*;
#(
  parameter logic [SMC_ID_W-1:0] LOCAL_SMC_ID = 5'd0
) (
  input  logic  clk,
  input  logic  rst_n,
  wur_if.slave  bus
);

  localparam int unsigned LAST_LINE = N_LINES - 1;

  // FSM / init sweep
  wur_state_e        state_q, state_d;
  logic              rdy_q, rdy_d;
  ur_key_t           cnt_q, cnt_d;
  logic              init_we_c;

  // Command decode
  ur_cmd_t           cmd_c;
  logic              accept_c;

  // S1 registers
  logic                          s1_vld_q;
  ur_key_t                       s1_key_q;
  logic [N_LANES-1:0][IDX_W-1:0] s1_idx_q;
  logic [N_LANES-1:0]            s1_lane_vld_q;
  ur_line_t                      s1_data_q;
  ur_line_t                      ram_rdata_q;

  // Forwarding of the line written on the previous edge
  logic              fwd_vld_q;
  ur_key_t           fwd_key_q;
  ur_line_t          fwd_line_q;

  // S2 merge and RAM write port
  ur_line_t          base_c;
  ur_line_t          merged_c;
  logic              pipe_we_c;
  logic              ram_we_c;
  ur_key_t           ram_waddr_c;
  ur_line_t          ram_wdata_c;

  // Outputs
  logic              done_q;
  ur_line_t          rd_data_q;

  ur_line_t          ram_q [N_LINES];

  assign bus.wur_rdy  = rdy_q;
  assign bus.wur_done = done_q;
  assign bus.rd_data  = rd_data_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; the clear sweep starts on the edge leaving RESET so the
  // block is not ready for exactly one cycle per cleared line.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_c = 1'b0;
    rdy_d     = 1'b0;
    unique case (state_q)
      ST_RESET: begin
`ifdef WUR_INIT_EN
        state_d   = ST_INIT;
        init_we_c = 1'b1;
        cnt_d     = cnt_q + KEY_W'(1);
`else
        state_d   = ST_RUN;
`endif
      end
      ST_INIT: begin
        init_we_c = 1'b1;
        cnt_d     = cnt_q + KEY_W'(1);
        if (cnt_q == KEY_W'(LAST_LINE)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
    rdy_d = (state_d == ST_RUN);
  end

  // Command acceptance
  always_comb begin
    cmd_c    = decode_cmd(bus.cru_wur);
    accept_c = rdy_q && cmd_c.vld && (cmd_c.smc_id == LOCAL_SMC_ID);
  end

  // S1: capture the command and read the target line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q      <= 1'b0;
      s1_key_q      <= '0;
      s1_idx_q      <= '0;
      s1_lane_vld_q <= '0;
      s1_data_q     <= '0;
      ram_rdata_q   <= '0;
    end else begin
      s1_vld_q <= accept_c;
      if (accept_c) begin
        s1_key_q      <= {cmd_c.ur_id, cmd_c.ur_addr};
        s1_idx_q      <= cmd_c.idx;
        s1_lane_vld_q <= cmd_c.lane_vld;
        s1_data_q     <= bus.dr_wur_d;
        ram_rdata_q   <= ram_q[{cmd_c.ur_id, cmd_c.ur_addr}];
      end
    end
  end

  // S2: the RAM read saw the pre-write contents if the previous command hit
  // the same line on that edge, so take the forwarded copy instead.
  always_comb begin
    base_c = (fwd_vld_q && (fwd_key_q == s1_key_q)) ? fwd_line_q : ram_rdata_q;
  end

  wur_byte_scatter u_scatter (
    .base_i     (base_c),
    .data_i     (s1_data_q),
    .idx_i      (s1_idx_q),
    .lane_vld_i (s1_lane_vld_q),
    .merged_c_o (merged_c)
  );

  // RAM write port: init clear and command writes never overlap
  always_comb begin
    pipe_we_c   = s1_vld_q && (|s1_lane_vld_q);
    ram_we_c    = init_we_c || pipe_we_c;
    ram_waddr_c = init_we_c ? cnt_q : s1_key_q;
    ram_wdata_c = init_we_c ? '0 : merged_c;
  end

  // UR-RAM storage (not reset)
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram_q[ram_waddr_c] <= ram_wdata_c;
    end
  end

  // Forwarding register, done pulse and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld_q  <= 1'b0;
      fwd_key_q  <= '0;
      fwd_line_q <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      fwd_vld_q <= pipe_we_c;
      if (pipe_we_c) begin
        fwd_key_q  <= s1_key_q;
        fwd_line_q <= merged_c;
      end
      done_q <= s1_vld_q;
      if (bus.rd_en) begin
        rd_data_q <= ram_q[{bus.rd_id, bus.rd_addr}];
      end
    end
  end

endmodule : wur

// File: tb/tb_wur.sv
// -----------------------------------------------------------------------------
// tb_wur
// Self-checking bench for wur. Keeps a byte-level reference copy of every
// touched UR line and compares read-back lines and done pulses against it.
// Honours WUR_INIT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_wur;

  localparam logic [4:0] MY_SMC = 5'd0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wur_if bus ();

  wur #(.LOCAL_SMC_ID(MY_SMC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [127:0] ref_mem [2048];

  // Build a raw command word straight from the field positions
  function automatic logic [96:0] mk_cmd(input logic v, input logic [4:0] smc,
                                         input logic [2:0] id, input logic [7:0] addr,
                                         input logic [15:0][3:0] idx, input logic [15:0] mask);
    logic [96:0] c;
    c = '0;
    c[96] = v;
    c[95:91] = smc;
    c[90:88] = id;
    c[87:80] = addr;
    for (int g = 0; g < 16; g++) begin
      c[79-5*g -: 4] = idx[g];
      c[75-5*g] = mask[g];
    end
    return c;
  endfunction

  // Reference scatter on a byte array
  function automatic logic [127:0] scatter_ref(input logic [127:0] base, input logic [127:0] data,
                                               input logic [15:0][3:0] idx, input logic [15:0] mask);
    logic [7:0] b [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = base[8*i +: 8];
    for (int g = 0; g < 16; g++) if (mask[g]) b[idx[g]] = data[8*g +: 8];
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [15:0][3:0] ident_idx();
    logic [15:0][3:0] x;
    for (int g = 0; g < 16; g++) x[g] = 4'(g);
    return x;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_idle();
    bus.cru_wur = '0;
    bus.dr_wur_d = '0;
  endtask

  // Drive a command for the coming edge; model updates if it will be accepted
  task automatic drive_cmd(input logic [4:0] smc, input logic [2:0] id, input logic [7:0] addr,
                           input logic [15:0][3:0] idx, input logic [15:0] mask,
                           input logic [127:0] data);
    bus.cru_wur = mk_cmd(1'b1, smc, id, addr, idx, mask);
    bus.dr_wur_d = data;
    if (smc == MY_SMC) ref_mem[{id, addr}] = scatter_ref(ref_mem[{id, addr}], data, idx, mask);
  endtask

  task automatic preset_line(input logic [2:0] id, input logic [7:0] addr, input logic [127:0] data);
    drive_cmd(MY_SMC, id, addr, ident_idx(), 16'hFFFF, data);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic read_line(input logic [2:0] id, input logic [7:0] addr, output logic [127:0] line);
    bus.rd_en = 1'b1;
    bus.rd_id = id;
    bus.rd_addr = addr;
    @(negedge clk);
    bus.rd_en = 1'b0;
    line = bus.rd_data;
  endtask

  task automatic test_reset();
    int n;
    logic [127:0] got;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.wur_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", bus.wur_rdy); end
    checks++;
    if (bus.wur_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.wur_done); end
    checks++;
    if (bus.rd_data !== 128'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.wur_rdy !== 1'b1 && n < 3000);
`ifdef WUR_INIT_EN
    checks++;
    if (n != 2048) begin failures++; $display("FAIL init_rdy_edges got=%0d exp=2048", n); end
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    read_line(3'd7, 8'hFF, got);
    checks++;
    if (got !== 128'h0) begin failures++; $display("FAIL init_last_line got=%h exp=0", got); end
    read_line(3'd0, 8'h00, got);
    checks++;
    if (got !== 128'h0) begin failures++; $display("FAIL init_first_line got=%h exp=0", got); end
`else
    checks++;
    if (n != 1) begin failures++; $display("FAIL rdy_edges got=%0d exp=1", n); end
`endif
  endtask

  task automatic test_identity();
    logic [127:0] data, got;
    for (int g = 0; g < 16; g++) data[8*g +: 8] = 8'(g);
    drive_cmd(MY_SMC, 3'd2, 8'h10, ident_idx(), 16'hFFFF, data);
    @(negedge clk);
    drive_idle();
    checks++;
    if (bus.wur_done !== 1'b0) begin failures++; $display("FAIL ident_done_early got=%b exp=0", bus.wur_done); end
    @(negedge clk);
    checks++;
    if (bus.wur_done !== 1'b1) begin failures++; $display("FAIL ident_done got=%b exp=1", bus.wur_done); end
    @(negedge clk);
    checks++;
    if (bus.wur_done !== 1'b0) begin failures++; $display("FAIL ident_done_pulse got=%b exp=0", bus.wur_done); end
    read_line(3'd2, 8'h10, got);
    checks++;
    if (got !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      failures++; $display("FAIL ident_line got=%h exp=0f0e0d0c0b0a09080706050403020100", got);
    end
  endtask

  task automatic test_partial();
    logic [15:0][3:0] idx;
    logic [127:0] got;
    preset_line(3'd1, 8'h20, {16{8'hAA}});
    idx = 64'({$urandom(), $urandom()});
    idx[0] = 4'd15;
    drive_cmd(MY_SMC, 3'd1, 8'h20, idx, 16'h0001, {rand_line()} & ~128'hFF | 128'h11);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    read_line(3'd1, 8'h20, got);
    checks++;
    if (got !== {8'h11, {15{8'hAA}}}) begin failures++; $display("FAIL partial_line got=%h exp=%h", got, {8'h11, {15{8'hAA}}}); end
  endtask

  task automatic test_conflict();
    logic [15:0][3:0] idx;
    logic [127:0] data, got;
    preset_line(3'd3, 8'h33, rand_line());
    idx = 64'({$urandom(), $urandom()});
    idx[3] = 4'd4;
    idx[9] = 4'd4;
    data = rand_line();
    data[8*3 +: 8] = 8'h33;
    data[8*9 +: 8] = 8'h99;
    drive_cmd(MY_SMC, 3'd3, 8'h33, idx, 16'h0208, data);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    read_line(3'd3, 8'h33, got);
    checks++;
    if (got[39:32] !== 8'h99) begin failures++; $display("FAIL conflict_byte4 got=%h exp=99", got[39:32]); end
    checks++;
    if (got !== ref_mem[{3'd3, 8'h33}]) begin failures++; $display("FAIL conflict_line got=%h exp=%h", got, ref_mem[{3'd3, 8'h33}]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0][3:0] idx;
    logic [127:0] data, got;
    int lane;
    preset_line(3'd5, 8'h80, rand_line());
    for (int k = 0; k < 8; k++) begin
      lane = $urandom_range(0, 15);
      idx = 64'({$urandom(), $urandom()});
      idx[lane] = 4'(k);
      data = rand_line();
      data[8*lane +: 8] = 8'(k + 1);
      drive_cmd(MY_SMC, 3'd5, 8'h80, idx, 16'(1 << lane), data);
      @(negedge clk);
      checks++;
      if (bus.wur_done !== (k >= 1)) begin failures++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, bus.wur_done, k >= 1); end
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.wur_done !== 1'b1) begin failures++; $display("FAIL b2b_done_last got=%b exp=1", bus.wur_done); end
    @(negedge clk);
    checks++;
    if (bus.wur_done !== 1'b0) begin failures++; $display("FAIL b2b_done_end got=%b exp=0", bus.wur_done); end
    read_line(3'd5, 8'h80, got);
    checks++;
    if (got[63:0] !== 64'h0807060504030201) begin failures++; $display("FAIL b2b_bytes got=%h exp=0807060504030201", got[63:0]); end
    checks++;
    if (got !== ref_mem[{3'd5, 8'h80}]) begin failures++; $display("FAIL b2b_line got=%h exp=%h", got, ref_mem[{3'd5, 8'h80}]); end
  endtask

  task automatic test_read_first();
    logic [127:0] old_line, got;
    preset_line(3'd6, 8'h01, rand_line());
    old_line = ref_mem[{3'd6, 8'h01}];
    drive_cmd(MY_SMC, 3'd6, 8'h01, ident_idx(), 16'hFFFF, ~old_line);
    @(negedge clk);
    drive_idle();
    read_line(3'd6, 8'h01, got);
    checks++;
    if (got !== old_line) begin failures++; $display("FAIL read_first_old got=%h exp=%h", got, old_line); end
    read_line(3'd6, 8'h01, got);
    checks++;
    if (got !== ~old_line) begin failures++; $display("FAIL read_first_new got=%h exp=%h", got, ~old_line); end
    bus.rd_id = 3'd2;
    bus.rd_addr = 8'h10;
    @(negedge clk);
    checks++;
    if (bus.rd_data !== ~old_line) begin failures++; $display("FAIL rd_hold got=%h exp=%h", bus.rd_data, ~old_line); end
  endtask

  task automatic test_wrong_id();
    logic [127:0] got;
    int seen;
    drive_cmd(MY_SMC + 5'd1, 3'd2, 8'h10, ident_idx(), 16'hFFFF, rand_line());
    @(negedge clk);
    drive_idle();
    seen = 0;
    repeat (3) begin @(negedge clk); if (bus.wur_done !== 1'b0) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL wrong_id_done got=%0d pulses exp=0", seen); end
    read_line(3'd2, 8'h10, got);
    checks++;
    if (got !== ref_mem[{3'd2, 8'h10}]) begin failures++; $display("FAIL wrong_id_line got=%h exp=%h", got, ref_mem[{3'd2, 8'h10}]); end
  endtask

  task automatic test_all_invalid();
    logic [127:0] got;
    drive_cmd(MY_SMC, 3'd1, 8'h20, ident_idx(), 16'h0000, rand_line());
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.wur_done !== 1'b1) begin failures++; $display("FAIL novld_done got=%b exp=1", bus.wur_done); end
    @(negedge clk);
    read_line(3'd1, 8'h20, got);
    checks++;
    if (got !== {8'h11, {15{8'hAA}}}) begin failures++; $display("FAIL novld_line got=%h exp=%h", got, {8'h11, {15{8'hAA}}}); end
  endtask

  task automatic test_reset_midop();
    logic [127:0] old_line, got;
    int n, seen;
    preset_line(3'd4, 8'h44, rand_line());
    old_line = ref_mem[{3'd4, 8'h44}];
    drive_cmd(MY_SMC, 3'd4, 8'h44, ident_idx(), 16'hFFFF, ~old_line);
    ref_mem[{3'd4, 8'h44}] = old_line;
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    seen = 0;
    repeat (2) begin @(negedge clk); if (bus.wur_done !== 1'b0) seen++; end
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; if (bus.wur_done !== 1'b0) seen++; end
    while (bus.wur_rdy !== 1'b1 && n < 3000);
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midrst_done got=%0d pulses exp=0", seen); end
    checks++;
    if (n >= 3000) begin failures++; $display("FAIL midrst_rdy_timeout got=%0d edges", n); end
`ifdef WUR_INIT_EN
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
`endif
    read_line(3'd4, 8'h44, got);
    checks++;
    if (got !== ref_mem[{3'd4, 8'h44}]) begin failures++; $display("FAIL midrst_line got=%h exp=%h", got, ref_mem[{3'd4, 8'h44}]); end
  endtask

  task automatic test_random();
    logic [10:0] keys [4];
    logic [127:0] got;
    logic prev_acc, acc;
    int sel, bad;
    for (int i = 0; i < 4; i++) begin
      keys[i] = 11'(i * 300 + 7);
      preset_line(keys[i][10:8], keys[i][7:0], rand_line());
    end
    prev_acc = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      acc = 1'b0;
      if (sel == 0) begin
        drive_idle();
      end else begin
        int k;
        k = $urandom_range(0, 3);
        drive_cmd((sel == 1) ? MY_SMC + 5'd3 : MY_SMC, keys[k][10:8], keys[k][7:0],
                  64'({$urandom(), $urandom()}), 16'($urandom()), rand_line());
        acc = (sel != 1);
      end
      @(negedge clk);
      if (bus.wur_done !== prev_acc) bad++;
      prev_acc = acc;
    end
    drive_idle();
    @(negedge clk);
    if (bus.wur_done !== prev_acc) bad++;
    @(negedge clk);
    if (bus.wur_done !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rand_done got=%0d mismatched cycles exp=0", bad); end
    for (int i = 0; i < 4; i++) begin
      read_line(keys[i][10:8], keys[i][7:0], got);
      checks++;
      if (got !== ref_mem[keys[i]]) begin failures++; $display("FAIL rand_line key=%0d got=%h exp=%h", keys[i], got, ref_mem[keys[i]]); end
    end
  endtask

  initial begin
    drive_idle();
    bus.rd_en = 1'b0;
    bus.rd_id = '0;
    bus.rd_addr = '0;
    test_reset();
    test_identity();
    test_partial();
    test_conflict();
    test_back_to_back();
    test_read_first();
    test_wrong_id();
    test_all_invalid();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule : tb_wur
